// File: rtl/serial_add_defs.sv
// Shared definitions for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package serial_add_defs;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full-adder cell.
// The serial adder uses it once per clock, LSB first.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with start/busy/done handshake.
// Optional SERIAL_ADD_OVF_EN adds a signed-overflow output ovf.
module serial_adder
   import serial_add_defs::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           st;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] r_sh;
   logic [CW-1:0]    cnt;
   logic             cy;
   logic             fs;
   logic             fc;
   logic [WIDTH-1:0] r_nxt;

   full_adder u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (cy),
      .s    (fs),
      .cout (fc)
   );

   assign r_nxt = {fs, r_sh[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= ST_IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         r_sh      <= '0;
         cnt       <= '0;
         cy        <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         unique case (st)
            ST_IDLE: begin
               if (start) begin
                  a_sh <= a;
                  b_sh <= b;
                  cy   <= 1'b0;
                  cnt  <= '0;
                  busy <= 1'b1;
                  st   <= ST_RUN;
               end
            end
            ST_RUN: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               r_sh <= r_nxt;
               cy   <= fc;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  sum       <= r_nxt;
                  carry_out <= fc;
`ifdef SERIAL_ADD_OVF_EN
                  // cy here is the carry into the MSB cell
                  ovf       <= cy ^ fc;
`endif
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  st        <= ST_DONE;
               end
            end
            ST_DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh <= a;
                  b_sh <= b;
                  cy   <= 1'b0;
                  cnt  <= '0;
                  busy <= 1'b1;
                  st   <= ST_RUN;
               end else begin
                  st <= ST_IDLE;
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder. It is the inverse-direction partner of the half subtractor: it adds a difference and a subtractand back into the original minuend.
- One full-adder cell plus a carry flop processes one bit per clock, LSB first.
- Used as the sequential arithmetic unit beside the combinational subtractor cells. A start/busy/done handshake lets a controller issue operations back to back.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request new addition; sampled only in IDLE and DONE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when sum/carry_out are valid
- sum  output  WIDTH  result a+b modulo 2^WIDTH; held until next accepted start
- carry_out  output  1  carry out of MSB; held with sum

Behaviour:
- One clock. Reset is asynchronous and active-low (rst_n); all state is reset on rst_n low without waiting for clk.
- Reset values:
  - state=IDLE, busy=0, done=0, sum=0, carry_out=0
  - internal shift registers=0, carry flop=0, bit counter=0
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - start=1 captures a, b into shift registers, clears carry flop, sets counter=0, goes to RUN.
  - start=0 stays in IDLE.
- RUN:
  - busy=1 every cycle.
  - Each cycle adds LSB(a_sh), LSB(b_sh) and carry via the full_adder cell.
  - The sum bit shifts into the MSB of the result shift register.
  - Operand registers shift right by one; the carry flop takes cout; counter increments.
  - When counter==WIDTH-1, that final bit completes: sum<=full result, carry_out<=final cout, go to DONE.
  - RUN lasts exactly WIDTH cycles.
- DONE:
  - done=1, busy=0 for exactly one cycle.
  - If start=1 in this cycle, new operands are captured and the next state is RUN (back-to-back, no IDLE gap). Otherwise the next state is IDLE.
- Latency: accepted start at edge k gives done high in cycle k+WIDTH+1. Throughput is one operation per WIDTH+1 cycles.
- start during RUN is ignored. Operands a/b may change freely after capture.
- sum/carry_out change only on the transition into DONE. They are stable at all other times, including in IDLE.
- rst_n asserted mid-RUN aborts immediately:
  - all outputs return to reset values
  - no done pulse is generated
  - after release, the block waits in IDLE for a fresh start.
- Arithmetic: unsigned; {carry_out,sum} == a+b exactly (WIDTH+1 bits).

Optional Feature:
- Macro SERIAL_ADD_OVF_EN.
- Defined:
  - adds output port ovf (1 bit, reset 0), updated together with sum.
  - ovf = two's-complement signed overflow = carry into MSB XOR carry out of MSB.
  - The carry into the MSB is registered during the last RUN cycle.
- Undefined: no ovf port and no extra flops; behaviour otherwise identical.

Decomposition:
- Shared include/package serial_add_defs: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, and the default WIDTH constant.
- Sub-module full_adder (a, b, cin -> s, cout) holds the per-bit combinational cell, instantiated once.
- Counter width is $clog2(WIDTH).

Test Plan:
- Reset then idle, WIDTH=8: rst_n low, then high for 20 cycles with start=0 -> busy=0, done=0, sum=0x00, carry_out=0 throughout.
- Basic add: a=0x35, b=0x0A, pulse start -> busy for 8 cycles, then done pulse with sum=0x3F, carry_out=0. Done arrives 9 cycles after the start edge.
- Carry and wrap: a=0xFF, b=0x01 -> sum=0x00, carry_out=1. With SERIAL_ADD_OVF_EN, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, carry_out=0, ovf=1.
- Inverse of subtractor: random a, b; compute d=a-b mod 256, then add d+b -> sum==a, over 1000 random pairs versus a reference model.
- Back-to-back: hold start=1 continuously with new operands each DONE cycle -> done every 9 cycles, no IDLE cycle between operations. A start asserted mid-RUN is ignored and does not corrupt the result.
- Reset mid-operation: assert rst_n low at the 4th RUN cycle of 0xAA+0x55 -> outputs 0 immediately, no done pulse. After release, a new 0x01+0x02 gives sum=0x03.
